// File: rtl/dcr_pkg.sv
// Shared definitions for the dcr_bank register bank: register addresses,
// CTRL/STATUS bit positions and the launch sequencer state encoding.
package dcr_pkg;

    localparam int DCR_CTRL         = 0;
    localparam int DCR_STATUS       = 1;
    localparam int DCR_THREAD_COUNT = 2;
    localparam int DCR_BASE_ADDR    = 3;
    localparam int DCR_CFG0         = 4;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_ERR_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } dcr_state_t;

    // Sticky flag update where a hardware set beats a host write-1-to-clear.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/dcr_launch_fsm.sv
// Kernel launch sequencer: IDLE -> LAUNCH (one-cycle start pulse) -> RUN until
// the dispatcher reports completion. Also flags illegal start requests.
module dcr_launch_fsm
    import dcr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start_req,
    input  logic thread_count_zero,
    input  logic kernel_done,
    output logic kernel_start,
    output logic busy,
    output logic done_set,
    output logic err_set
);

    dcr_state_t state_r;
    dcr_state_t next_state_s;
    logic       kernel_start_r;
    logic       busy_r;
    logic       kernel_start_next_s;
    logic       busy_next_s;

    // State register; kernel_start and busy are registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            kernel_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            kernel_start_r <= kernel_start_next_s;
            busy_r         <= busy_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_req && !thread_count_zero) begin
                    next_state_s = LAUNCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LAUNCH: next_state_s = RUN;
            RUN: begin
                if (kernel_done) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: next-cycle pulse/busy plus same-cycle flag strobes
    always_comb begin
        kernel_start_next_s = (next_state_s == LAUNCH);
        busy_next_s         = (next_state_s != IDLE);
        done_set            = (state_r == RUN) && kernel_done;
        // A start is illegal while a kernel is in flight or with no threads
        err_set             = start_req && ((state_r != IDLE) || thread_count_zero);
    end

    assign kernel_start = kernel_start_r;
    assign busy         = busy_r;

endmodule

// File: rtl/dcr_bank.sv
// Host-addressable device control register bank with kernel launch sequencer.
// Define DCR_CYCLE_COUNT_EN to map a read-only run-cycle counter at the top address.
module dcr_bank
    import dcr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_CFG    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dcr_wr_en,
    input  logic                          dcr_rd_en,
    input  logic [ADDR_WIDTH-1:0]         dcr_addr,
    input  logic [DATA_WIDTH-1:0]         dcr_wdata,
    output logic [DATA_WIDTH-1:0]         dcr_rdata,
    output logic                          dcr_rvalid,
    output logic [DATA_WIDTH-1:0]         thread_count,
    output logic [DATA_WIDTH-1:0]         base_addr,
    output logic [NUM_CFG*DATA_WIDTH-1:0] cfg,
    output logic                          kernel_start,
    input  logic                          kernel_done,
    output logic                          busy,
    output logic                          irq
);

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

    logic                  hit_ctrl_s;
    logic                  hit_status_s;
    logic                  hit_tc_s;
    logic                  hit_ba_s;
    logic                  hit_cc_s;
    logic [NUM_CFG-1:0]    hit_cfg_s;
    logic                  mapped_s;

    logic                  wr_ctrl_s;
    logic                  wr_status_s;
    logic                  start_req_s;
    logic                  locked_wr_s;
    logic                  unmapped_wr_s;
    logic                  cfg_wr_en_s;
    logic                  irq_en_next_s;
    logic                  done_next_s;
    logic                  err_next_s;
    logic                  tc_zero_s;
    logic [DATA_WIDTH-1:0] rd_mux_s;

    logic                  kernel_start_s;
    logic                  busy_s;
    logic                  fsm_done_set_s;
    logic                  fsm_err_set_s;

    logic                  irq_en_r;
    logic                  done_r;
    logic                  err_r;
    logic                  irq_r;
    logic [DATA_WIDTH-1:0] tc_r;
    logic [DATA_WIDTH-1:0] ba_r;
    logic [DATA_WIDTH-1:0] cfg_r [NUM_CFG];
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rvalid_r;

`ifdef DCR_CYCLE_COUNT_EN
    localparam logic [DATA_WIDTH-1:0] ONES_WORD = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ONE_WORD  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    logic [DATA_WIDTH-1:0] cycle_count_r;
`endif

    // Address decode; the cycle counter address shadows any CFG register there
    always_comb begin
        hit_ctrl_s   = (dcr_addr == ADDR_WIDTH'(DCR_CTRL));
        hit_status_s = (dcr_addr == ADDR_WIDTH'(DCR_STATUS));
        hit_tc_s     = (dcr_addr == ADDR_WIDTH'(DCR_THREAD_COUNT));
        hit_ba_s     = (dcr_addr == ADDR_WIDTH'(DCR_BASE_ADDR));
        for (int k = 0; k < NUM_CFG; k++) begin
            hit_cfg_s[k] = (dcr_addr == ADDR_WIDTH'(DCR_CFG0 + k));
        end
`ifdef DCR_CYCLE_COUNT_EN
        hit_cc_s  = (dcr_addr == {ADDR_WIDTH{1'b1}});
        hit_cfg_s = hit_cfg_s & {NUM_CFG{~hit_cc_s}};
`else
        hit_cc_s  = 1'b0;
`endif
        mapped_s = hit_ctrl_s | hit_status_s | hit_tc_s | hit_ba_s | (|hit_cfg_s) | hit_cc_s;
    end

    // Write strobes and next values of control/status bits
    always_comb begin
        wr_ctrl_s     = dcr_wr_en & hit_ctrl_s;
        wr_status_s   = dcr_wr_en & hit_status_s;
        start_req_s   = wr_ctrl_s & dcr_wdata[CTRL_START_BIT];
        cfg_wr_en_s   = dcr_wr_en & ~busy_s;
        locked_wr_s   = dcr_wr_en & busy_s & (hit_tc_s | hit_ba_s | (|hit_cfg_s));
        unmapped_wr_s = dcr_wr_en & ~mapped_s;
        tc_zero_s     = (tc_r == ZERO_WORD);
        irq_en_next_s = wr_ctrl_s ? dcr_wdata[CTRL_IRQ_EN_BIT] : irq_en_r;
        done_next_s   = sticky_next(done_r, fsm_done_set_s,
                                    wr_status_s & dcr_wdata[STATUS_DONE_BIT]);
        err_next_s    = sticky_next(err_r, fsm_err_set_s | locked_wr_s | unmapped_wr_s,
                                    wr_status_s & dcr_wdata[STATUS_ERR_BIT]);
    end

    dcr_launch_fsm u_launch_fsm (
        .clk               (clk),
        .reset             (reset),
        .start_req         (start_req_s),
        .thread_count_zero (tc_zero_s),
        .kernel_done       (kernel_done),
        .kernel_start      (kernel_start_s),
        .busy              (busy_s),
        .done_set          (fsm_done_set_s),
        .err_set           (fsm_err_set_s)
    );

    // Control, status and configuration registers; config is frozen while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            irq_r    <= 1'b0;
            tc_r     <= ZERO_WORD;
            ba_r     <= ZERO_WORD;
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_r[k] <= ZERO_WORD;
            end
        end else begin
            irq_en_r <= irq_en_next_s;
            done_r   <= done_next_s;
            err_r    <= err_next_s;
            irq_r    <= done_next_s & irq_en_next_s;
            if (cfg_wr_en_s && hit_tc_s) begin
                tc_r <= dcr_wdata;
            end
            if (cfg_wr_en_s && hit_ba_s) begin
                ba_r <= dcr_wdata;
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                if (cfg_wr_en_s && hit_cfg_s[k]) begin
                    cfg_r[k] <= dcr_wdata;
                end
            end
        end
    end

`ifdef DCR_CYCLE_COUNT_EN
    // Run-cycle counter: cleared on the launch pulse, saturating count of RUN cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_r <= ZERO_WORD;
        end else if (kernel_start_s) begin
            cycle_count_r <= ZERO_WORD;
        end else if (busy_s && (cycle_count_r != ONES_WORD)) begin
            cycle_count_r <= cycle_count_r + ONE_WORD;
        end
    end
`endif

    // Read mux over current (pre-write) register values
    always_comb begin
        rd_mux_s = ZERO_WORD;
        if (hit_ctrl_s) begin
            rd_mux_s[CTRL_IRQ_EN_BIT] = irq_en_r;
        end else if (hit_status_s) begin
            rd_mux_s[STATUS_BUSY_BIT] = busy_s;
            rd_mux_s[STATUS_DONE_BIT] = done_r;
            rd_mux_s[STATUS_ERR_BIT]  = err_r;
        end else if (hit_tc_s) begin
            rd_mux_s = tc_r;
        end else if (hit_ba_s) begin
            rd_mux_s = ba_r;
`ifdef DCR_CYCLE_COUNT_EN
        end else if (hit_cc_s) begin
            rd_mux_s = cycle_count_r;
`endif
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (hit_cfg_s[k]) begin
                    rd_mux_s = cfg_r[k];
                end
            end
        end
    end

    // Registered read port: one-cycle valid pulse, data held until the next read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r  <= ZERO_WORD;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= dcr_rd_en;
            if (dcr_rd_en) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg[g*DATA_WIDTH +: DATA_WIDTH] = cfg_r[g];
    end

    assign dcr_rdata    = rdata_r;
    assign dcr_rvalid   = rvalid_r;
    assign thread_count = tc_r;
    assign base_addr    = ba_r;
    assign kernel_start = kernel_start_s;
    assign busy         = busy_s;
    assign irq          = irq_r;

endmodule

// File: tb/tb_dcr_bank.sv
// Scoreboard bench for dcr_bank: directed scenarios plus random host traffic,
// checked against a register-map level model of the bank.
module tb_dcr_bank;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dcr_wr_en = 1'b0;
    logic          dcr_rd_en = 1'b0;
    logic [AW-1:0] dcr_addr = '0;
    logic [DW-1:0] dcr_wdata = '0;
    logic          kernel_done = 1'b0;
    logic [DW-1:0] dcr_rdata;
    logic          dcr_rvalid;
    logic [DW-1:0] thread_count;
    logic [DW-1:0] base_addr;
    logic [NC*DW-1:0] cfg;
    logic          kernel_start;
    logic          busy;
    logic          irq;

    dcr_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CFG(NC)) dut (
        .clk(clk), .reset(reset), .dcr_wr_en(dcr_wr_en), .dcr_rd_en(dcr_rd_en),
        .dcr_addr(dcr_addr), .dcr_wdata(dcr_wdata), .dcr_rdata(dcr_rdata),
        .dcr_rvalid(dcr_rvalid), .thread_count(thread_count), .base_addr(base_addr),
        .cfg(cfg), .kernel_start(kernel_start), .kernel_done(kernel_done),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: phase 0 = idle, 1 = launch cycle, 2 = running
    int           phase = 0;
    bit           m_irq_en = 0, m_done = 0, m_err = 0;
    logic [DW-1:0] m_tc = '0, m_ba = '0, m_cc = '0;
    logic [DW-1:0] m_cfg [NC] = '{default: '0};

    logic [DW-1:0] exp_q[$];
    int            exp_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit is_cc(input int a);
`ifdef DCR_CYCLE_COUNT_EN
        return a == (1 << AW) - 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_cfg(input int a);
        return (a >= 4) && (a < 4 + NC) && !is_cc(a);
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 0) return {6'd0, m_irq_en, 1'b0};
        if (a == 1) return {5'd0, m_err, m_done, (phase != 0)};
        if (a == 2) return m_tc;
        if (a == 3) return m_ba;
        if (is_cc(a)) return m_cc;
        if (is_cfg(a)) return m_cfg[a-4];
        return 8'd0;
    endfunction

    // One host cycle; exp_rd >= 0 overrides the model's read expectation
    task automatic cycle(input bit wr, input bit rd, input int a, input logic [DW-1:0] wd,
                         input bit kd, input int exp_rd = -1);
        int n_phase;
        bit set_err, set_done, clr_done, clr_err, busy_now;
        dcr_wr_en = wr; dcr_rd_en = rd; dcr_addr = a[AW-1:0]; dcr_wdata = wd; kernel_done = kd;
        if (rd) begin
            exp_q.push_back((exp_rd >= 0) ? exp_rd[DW-1:0] : model_read(a));
            exp_cyc.push_back(cyc);
        end
        busy_now = (phase != 0);
        n_phase  = (phase == 1) ? 2 : ((phase == 2 && kd) ? 0 : phase);
        set_done = (phase == 2) && kd;
        set_err = 0; clr_done = 0; clr_err = 0;
        @(posedge clk);
        #1;
        if (wr) begin
            if (a == 0) begin
                m_irq_en = wd[1];
                if (wd[0]) begin
                    if (busy_now || m_tc == 0) set_err = 1;
                    else n_phase = 1;
                end
            end else if (a == 1) begin
                clr_done = wd[1]; clr_err = wd[2];
            end else if (a == 2 || a == 3 || is_cfg(a)) begin
                if (busy_now) set_err = 1;
                else if (a == 2) m_tc = wd;
                else if (a == 3) m_ba = wd;
                else m_cfg[a-4] = wd;
            end else if (!is_cc(a)) begin
                set_err = 1;
            end
        end
        if (phase == 1) m_cc = '0;
        else if (phase == 2 && m_cc != 8'hFF) m_cc = m_cc + 8'd1;
        m_done = set_done | (m_done & !clr_done);
        m_err  = set_err  | (m_err  & !clr_err);
        phase  = n_phase;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        #2;
        reset = 1'b0;
        dcr_wr_en = 0; dcr_rd_en = 0; kernel_done = 0;
        phase = 0; m_irq_en = 0; m_done = 0; m_err = 0;
        m_tc = '0; m_ba = '0; m_cc = '0;
        for (int k = 0; k < NC; k++) m_cfg[k] = '0;
        exp_q.delete(); exp_cyc.delete();
        #1;
        chk("rst_rdata", dcr_rdata, 0);
        chk("rst_rvalid", dcr_rvalid, 0);
        chk("rst_kernel_start", kernel_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_thread_count", thread_count, 0);
        chk("rst_base_addr", base_addr, 0);
        chk("rst_cfg", cfg, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle output comparison and read-data scoreboard
    initial begin
        logic [DW-1:0] d;
        int c;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("kernel_start", kernel_start, phase == 1);
                chk("busy", busy, phase != 0);
                chk("irq", irq, m_done & m_irq_en);
                chk("thread_count", thread_count, m_tc);
                chk("base_addr", base_addr, m_ba);
                chk("cfg", cfg, {m_cfg[2], m_cfg[1], m_cfg[0]});
                if (dcr_rvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("rvalid_unexpected", 1, 0);
                    end else begin
                        d = exp_q.pop_front();
                        c = exp_cyc.pop_front();
                        chk("rdata", dcr_rdata, d);
                        chk("rd_latency", cyc, c + 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset value and basic launch
        cycle(0, 1, 2, 8'h00, 0, 8'h00);
        cycle(1, 0, 2, 8'h20, 0);
        cycle(1, 0, 0, 8'h01, 0);
        idle(3);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 1, 1, 8'h00, 0, 8'h02);
        // Zero-thread launch
        cycle(1, 0, 1, 8'h02, 0);
        cycle(1, 0, 2, 8'h00, 0);
        cycle(1, 0, 0, 8'h01, 0);
        cycle(0, 1, 1, 8'h00, 0, 8'h04);
        // Locked configuration while busy
        cycle(1, 0, 1, 8'h04, 0);
        cycle(1, 0, 2, 8'h20, 0);
        cycle(1, 0, 0, 8'h01, 0);
        cycle(1, 0, 2, 8'h05, 0);
        cycle(0, 1, 1, 8'h00, 0, 8'h05);
        cycle(1, 0, 1, 8'h04, 0);
        cycle(0, 1, 1, 8'h00, 0, 8'h01);
        // Interrupt and set-beats-clear
        cycle(1, 0, 0, 8'h02, 0);
        cycle(0, 0, 0, 8'h00, 1);
        idle(1);
        cycle(1, 0, 0, 8'h03, 0);
        idle(2);
        cycle(1, 0, 1, 8'h02, 1);
        cycle(0, 1, 1, 8'h00, 0, 8'h02);
        // Simultaneous read and write returns the old value
        cycle(1, 1, 3, 8'hA5, 0, 8'h00);
        cycle(0, 1, 3, 8'h00, 0, 8'hA5);
        // Reset in the middle of a run
        cycle(1, 0, 0, 8'h01, 0);
        idle(2);
        reset_mid_run();
        cycle(0, 1, 1, 8'h00, 0, 8'h00);
        cycle(0, 1, 2, 8'h00, 0, 8'h00);
`ifdef DCR_CYCLE_COUNT_EN
        cycle(1, 0, 2, 8'h07, 0);
        cycle(1, 0, 0, 8'h01, 0);
        idle(10);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 1, 7, 8'h00, 0, 8'd10);
        cycle(1, 0, 0, 8'h01, 0);
        idle(300);
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 1, 7, 8'h00, 0, 8'hFF);
`endif
        // Random host traffic
        for (int i = 0; i < 600; i++) begin
            bit wr, rd, kd;
            int a;
            logic [DW-1:0] wd;
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 2) == 0);
            a  = $urandom_range(0, 7);
            wd = 8'($urandom);
            if (a == 2 && $urandom_range(0, 3) == 0) wd = 8'h00;
            kd = (phase == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
            cycle(wr, rd, a, wd, kd);
        end
        idle(3);
        chk("rd_queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
